// File: rtl/occ_width_writeback_pkg.sv
// Shared sizes, types and FSM encoding for the occupied-width writeback slice.
// Pure declarations: no latency, no backpressure.
package occ_pkg;
  localparam int NUM_STRIPS = 14;
  localparam int STRIP_CAP  = 128;
  localparam int OCC_W      = 8;

  typedef logic [3:0]       strip_id_t;
  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [4:0]       width_t;

  typedef enum logic {CLEAR, IDLE} state_e;

  localparam strip_id_t LAST_ID = strip_id_t'(NUM_STRIPS - 1);
  localparam occ_t      CAP_OCC = occ_t'(STRIP_CAP);

  // Id 0 is the sentinel; anything past the last strip has no storage.
  function automatic logic id_valid(strip_id_t id);
    return (id != '0) && (id <= LAST_ID);
  endfunction
endpackage

// File: rtl/occ_width_writeback_if.sv
// Front-end facing bundle: commit request, done strobe, clear, three read ports.
// No latency of its own; wr_valid/wr_ready handshake carries the backpressure.
interface occ_width_writeback_if import occ_pkg::*;;
  logic      wr_valid;
  logic      wr_ready;
  strip_id_t wr_str_id;
  width_t    wr_width;
  logic      clr_req;
  strip_id_t rd_str_id_1, rd_str_id_2, rd_str_id_3;
  occ_t      rd_occ_width_1, rd_occ_width_2, rd_occ_width_3;
  logic      done_valid;
  logic      done_ok;
  strip_id_t done_str_id;
  occ_t      done_occ_width;
  logic      busy;

  modport master (
    output wr_valid, wr_str_id, wr_width, clr_req,
    output rd_str_id_1, rd_str_id_2, rd_str_id_3,
    input  wr_ready, rd_occ_width_1, rd_occ_width_2, rd_occ_width_3,
    input  done_valid, done_ok, done_str_id, done_occ_width, busy
  );

  modport slave (
    input  wr_valid, wr_str_id, wr_width, clr_req,
    input  rd_str_id_1, rd_str_id_2, rd_str_id_3,
    output wr_ready, rd_occ_width_1, rd_occ_width_2, rd_occ_width_3,
    output done_valid, done_ok, done_str_id, done_occ_width, busy
  );
endinterface

// File: rtl/occ_width_writeback_table.sv
// Occupied-width register array: one write port, one combinational RMW read, three registered reads.
// Read latency one edge; never stalls. OCC_BYPASS_EN forwards same-edge writes to the read ports.
module occ_width_table import occ_pkg::*; (
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  strip_id_t wr_id,
  input  occ_t      wr_occ,
  input  strip_id_t rmw_id,
  output occ_t      rmw_occ,
  input  strip_id_t rd_id_1,
  input  strip_id_t rd_id_2,
  input  strip_id_t rd_id_3,
  output occ_t      rd_occ_1,
  output occ_t      rd_occ_2,
  output occ_t      rd_occ_3
);
  occ_t      mem_q [NUM_STRIPS];
  occ_t      mem_d [NUM_STRIPS];
  strip_id_t rd_id [3];
  occ_t      rd_occ_d [3];
  occ_t      rd_occ_q [3];

  assign rd_id[0] = rd_id_1;
  assign rd_id[1] = rd_id_2;
  assign rd_id[2] = rd_id_3;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_id] = wr_occ;
  end

  // Writes only ever target valid ids, so forwarding lives inside the valid branch.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_occ_d[k] = CAP_OCC;
      if (id_valid(rd_id[k])) begin
        rd_occ_d[k] = mem_q[rd_id[k]];
`ifdef OCC_BYPASS_EN
        if (we && (wr_id == rd_id[k])) rd_occ_d[k] = wr_occ;
`endif
      end
    end
  end

  assign rmw_occ = id_valid(rmw_id) ? mem_q[rmw_id] : CAP_OCC;

  // Contents are not reset here; the top sweeps every real strip after reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) rd_occ_q[k] <= '0;
    end else begin
      rd_occ_q <= rd_occ_d;
    end
  end

  assign rd_occ_1 = rd_occ_q[0];
  assign rd_occ_2 = rd_occ_q[1];
  assign rd_occ_3 = rd_occ_q[2];
endmodule

// File: rtl/occ_width_writeback.sv
// Per-strip occupied-width writer: capacity-checked add, clear sweep, three read ports (OCC_BYPASS_EN option).
// Accept edge N, done strobe edge N+1, reads one edge; wr_ready low while sweeping or on clr_req.
module occ_width_writeback import occ_pkg::*; (
  input logic clk,
  input logic rst,
  occ_width_writeback_if.slave bus
);
  state_e    state_q, state_d;
  strip_id_t cnt_q, cnt_d;
  logic      s1_vld_q, s1_vld_d;
  strip_id_t s1_id_q, s1_id_d;
  width_t    s1_width_q, s1_width_d;
  logic      done_vld_q, done_vld_d;
  logic      done_ok_q, done_ok_d;
  strip_id_t done_id_q, done_id_d;
  occ_t      done_occ_q, done_occ_d;

  logic           tbl_we;
  strip_id_t      tbl_wr_id;
  occ_t           tbl_wr_occ;
  occ_t           rmw_occ;
  logic [OCC_W:0] sum;
  logic           commit_ok;
  logic           accept;

  assign accept    = bus.wr_valid && bus.wr_ready;
  assign sum       = {1'b0, rmw_occ} + {{(OCC_W-4){1'b0}}, s1_width_q};
  assign commit_ok = s1_vld_q && id_valid(s1_id_q) && (sum <= (OCC_W+1)'(STRIP_CAP));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s1_vld_d   = accept;
    s1_id_d    = accept ? bus.wr_str_id : s1_id_q;
    s1_width_d = accept ? bus.wr_width  : s1_width_q;
    done_vld_d = s1_vld_q;
    done_ok_d  = done_ok_q;
    done_id_d  = done_id_q;
    done_occ_d = done_occ_q;
    tbl_we     = 1'b0;
    tbl_wr_id  = cnt_q;
    tbl_wr_occ = '0;

    if (s1_vld_q) begin
      done_ok_d  = commit_ok;
      done_id_d  = s1_id_q;
      done_occ_d = commit_ok ? sum[OCC_W-1:0] : rmw_occ;
    end

    // S1 only fills in IDLE, so a commit and a sweep write never share an edge.
    case (state_q)
      CLEAR: begin
        tbl_we = 1'b1;
        cnt_d  = strip_id_t'(cnt_q + 4'd1);
        if (cnt_q == LAST_ID) state_d = IDLE;
      end
      default: begin
        if (commit_ok) begin
          tbl_we     = 1'b1;
          tbl_wr_id  = s1_id_q;
          tbl_wr_occ = sum[OCC_W-1:0];
        end
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= 4'd1;
      s1_vld_q   <= 1'b0;
      s1_id_q    <= '0;
      s1_width_q <= '0;
      done_vld_q <= 1'b0;
      done_ok_q  <= 1'b0;
      done_id_q  <= '0;
      done_occ_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_id_q    <= s1_id_d;
      s1_width_q <= s1_width_d;
      done_vld_q <= done_vld_d;
      done_ok_q  <= done_ok_d;
      done_id_q  <= done_id_d;
      done_occ_q <= done_occ_d;
    end
  end

  occ_width_table u_table (
    .clk      (clk),
    .rst      (rst),
    .we       (tbl_we),
    .wr_id    (tbl_wr_id),
    .wr_occ   (tbl_wr_occ),
    .rmw_id   (s1_id_q),
    .rmw_occ  (rmw_occ),
    .rd_id_1  (bus.rd_str_id_1),
    .rd_id_2  (bus.rd_str_id_2),
    .rd_id_3  (bus.rd_str_id_3),
    .rd_occ_1 (bus.rd_occ_width_1),
    .rd_occ_2 (bus.rd_occ_width_2),
    .rd_occ_3 (bus.rd_occ_width_3)
  );

  assign bus.busy           = (state_q == CLEAR);
  assign bus.wr_ready       = (state_q == IDLE) && !bus.clr_req;
  assign bus.done_valid     = done_vld_q;
  assign bus.done_ok        = done_ok_q;
  assign bus.done_str_id    = done_id_q;
  assign bus.done_occ_width = done_occ_q;
endmodule

// File: tb/tb_occ_width_writeback.sv
// Directed bench for occ_width_writeback: reset sweep, adds, overflow, bad ids, bypass, clear, mid-op reset.
// Outputs sampled 1 time unit after each rising edge.
module tb_occ_width_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  occ_width_writeback_if bus ();

  occ_width_writeback dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input string tag, input int already);
    int n;
    n = already;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    chk(tag, n, 13);
  endtask

  // Single isolated request: accept edge, then commit edge, then check the strobe.
  task automatic wr_one(input string tag, input logic [3:0] id, input logic [4:0] w,
                        input logic exp_ok, input logic [7:0] exp_occ);
    bus.wr_valid = 1'b1; bus.wr_str_id = id; bus.wr_width = w;
    tick();
    bus.wr_valid = 1'b0;
    tick();
    chk({tag, "_vld"}, bus.done_valid, 1);
    chk({tag, "_ok"},  bus.done_ok, exp_ok);
    chk({tag, "_occ"}, bus.done_occ_width, exp_occ);
    chk({tag, "_id"},  bus.done_str_id, id);
  endtask

  initial begin
    bus.wr_valid = 0; bus.wr_str_id = 0; bus.wr_width = 0; bus.clr_req = 0;
    bus.rd_str_id_1 = 0; bus.rd_str_id_2 = 0; bus.rd_str_id_3 = 0;

    // Reset state
    tick();
    chk("rst_busy", bus.busy, 1);
    chk("rst_ready", bus.wr_ready, 0);
    chk("rst_done_vld", bus.done_valid, 0);
    chk("rst_done_occ", bus.done_occ_width, 0);
    chk("rst_rd1", bus.rd_occ_width_1, 0);
    rst = 0;
    count_busy("init_sweep_len", 0);
    chk("init_ready", bus.wr_ready, 1);

    bus.rd_str_id_1 = 1; bus.rd_str_id_2 = 5; bus.rd_str_id_3 = 13;
    tick();
    chk("init_rd_1", bus.rd_occ_width_1, 0);
    chk("init_rd_5", bus.rd_occ_width_2, 0);
    chk("init_rd_13", bus.rd_occ_width_3, 0);
    bus.rd_str_id_1 = 0; bus.rd_str_id_2 = 14; bus.rd_str_id_3 = 15;
    tick();
    chk("sentinel_rd", bus.rd_occ_width_1, 128);
    chk("oob14_rd", bus.rd_occ_width_2, 128);
    chk("oob15_rd", bus.rd_occ_width_3, 128);

    // Back-to-back writes to strip 3
    bus.wr_valid = 1; bus.wr_str_id = 3; bus.wr_width = 20;
    tick();
    bus.wr_width = 30;
    tick();
    bus.wr_valid = 0;
    chk("b2b_a_vld", bus.done_valid, 1);
    chk("b2b_a_occ", bus.done_occ_width, 20);
    chk("b2b_a_ok", bus.done_ok, 1);
    tick();
    chk("b2b_b_vld", bus.done_valid, 1);
    chk("b2b_b_occ", bus.done_occ_width, 50);
    chk("b2b_b_ok", bus.done_ok, 1);
    bus.rd_str_id_1 = 3;
    tick();
    chk("b2b_strobe_end", bus.done_valid, 0);
    chk("b2b_rd3", bus.rd_occ_width_1, 50);

    // Fill strip 7 up to the capacity edge
    wr_one("s7_1", 7, 31, 1, 31);
    wr_one("s7_2", 7, 31, 1, 62);
    wr_one("s7_3", 7, 31, 1, 93);
    wr_one("s7_4", 7, 31, 1, 124);
    wr_one("s7_5", 7, 31, 0, 124);
    wr_one("w0_s3", 3, 0, 1, 50);
    bus.rd_str_id_1 = 7;
    tick();
    chk("s7_rd", bus.rd_occ_width_1, 124);

    // Invalid ids
    wr_one("id0", 0, 5, 0, 128);
    wr_one("id14", 14, 5, 0, 128);
    bus.rd_str_id_1 = 0;
    tick();
    chk("id0_rd_after", bus.rd_occ_width_1, 128);

    // Same-edge commit and read of strip 2
    bus.rd_str_id_1 = 2;
    bus.wr_valid = 1; bus.wr_str_id = 2; bus.wr_width = 10;
    tick();
    bus.wr_valid = 0;
    tick();
`ifdef OCC_BYPASS_EN
    chk("bypass_rd2", bus.rd_occ_width_1, 10);
`else
    chk("bypass_rd2", bus.rd_occ_width_1, 0);
`endif
    tick();
    chk("post_rd2", bus.rd_occ_width_1, 10);

    // Clear request while S1 is pending and a new write is offered
    bus.wr_valid = 1; bus.wr_str_id = 4; bus.wr_width = 5;
    tick();
    bus.clr_req = 1; bus.wr_width = 6;
    #1;
    chk("clr_ready", bus.wr_ready, 0);
    tick();
    bus.clr_req = 0; bus.wr_valid = 0;
    chk("clr_pend_vld", bus.done_valid, 1);
    chk("clr_pend_occ", bus.done_occ_width, 5);
    chk("clr_pend_ok", bus.done_ok, 1);
    chk("clr_busy", bus.busy, 1);
    tick();
    chk("clr_no_2nd", bus.done_valid, 0);
    count_busy("clr_sweep_len", 1);
    for (int id = 1; id < 14; id++) begin
      bus.rd_str_id_2 = 4'(id);
      tick();
      chk($sformatf("clr_rd_%0d", id), bus.rd_occ_width_2, 0);
    end

    // Reset on the commit edge drops the pending request
    bus.wr_valid = 1; bus.wr_str_id = 5; bus.wr_width = 3;
    tick();
    bus.wr_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("mrst_no_done", bus.done_valid, 0);
    chk("mrst_busy", bus.busy, 1);
    count_busy("mrst_sweep_len", 0);
    bus.rd_str_id_3 = 5;
    tick();
    chk("mrst_rd5", bus.rd_occ_width_3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/occ_width_writeback.md
# occ_width_writeback

Back-end writer of the placement pipeline's per-strip occupied-width table. It accepts committed placements (strip id plus program width) and performs an add-with-capacity-check read-modify-write on the table. It serves the three registered strip-id read ports used by the front-end find-row/read stage. It owns table initialisation, sweeping all strips back to empty after reset or on request.

## Interface
- NUM_STRIPS, 14: table entries. Id 0 is the sentinel, ids 1..NUM_STRIPS-1 are real strips.
- STRIP_CAP, 128: strip capacity in width units, returned for the sentinel.
- OCC_W, 8: occupied-width bit width.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- wr_valid  in  1  placement commit request.
- wr_ready  out  1  request accepted on an edge where wr_valid && wr_ready.
- wr_str_id  in  4  target strip id.
- wr_width  in  5  program width to add.
- clr_req  in  1  start a table-clear sweep.
- rd_str_id_1/2/3  in  4  read ids from the front end.
- rd_occ_width_1/2/3  out  OCC_W  registered occupied width per read id.
- done_valid  out  1  one-cycle commit result strobe.
- done_ok  out  1  1 = width added, 0 = rejected.
- done_str_id  out  4  id of the completed request.
- done_occ_width  out  OCC_W  table value after the commit, or the unchanged value if rejected.
- busy  out  1  high while sweeping.

## Operation
- FSM states: CLEAR and IDLE.
  - CLEAR: sweep counter steps 1..NUM_STRIPS-1, writing 0 to one entry per cycle. After entry NUM_STRIPS-1 is written, go to IDLE.
  - IDLE: on clr_req sampled high, go to CLEAR with counter = 1.
- wr_ready = (state==IDLE) && !clr_req.
- Accepted request is captured into stage S1 (valid, id, width).
- Next edge commits S1:
  - sum = table[id] + width, computed 9-bit.
  - ok = (id in 1..NUM_STRIPS-1) && (sum <= STRIP_CAP).
  - On ok, write sum[7:0] to the table.
  - done_* registered on the same edge.
- Rejected request (id 0, id >= NUM_STRIPS, or overflow): table unchanged, done_ok=0. For an invalid id, done_occ_width = STRIP_CAP.
- wr_width=0 to a valid id: ok=1, value unchanged.
- A pending S1 always commits, even on the edge that enters CLEAR. The sweep then overwrites it.
- Read ports, on every edge:
  - rd_occ_width_k <= table[rd_str_id_k].
  - Id 0 and ids >= NUM_STRIPS return STRIP_CAP.
  - Read ports operate in all states and return the mid-sweep table contents.

## Timing
- Reset values:
  - state=CLEAR, counter=1, S1 empty.
  - busy=1, wr_ready=0.
  - done_valid=0, done_ok=0, done_str_id=0, done_occ_width=0.
  - rd_occ_width_1/2/3=0.
- Reset followed by rst low: busy stays high for NUM_STRIPS-1 (13) cycles, then wr_ready=1.
- Write latency:
  - Accept at edge N, commit and done_valid=1 at edge N+1.
  - done_valid lasts exactly one cycle unless another commit follows.
- Throughput: one request per cycle. Back-to-back writes to the same strip read the already-committed value, so no hazard stall is needed.
- Read latency: one edge.
- rst asserted mid-operation: S1 is discarded with no done strobe, and the sweep restarts at 1.

## Configuration
- OCC_BYPASS_EN defined: if a commit to strip k and a read of strip k occur on the same edge, the read port returns the new sum.
- OCC_BYPASS_EN undefined: that read returns the pre-commit value. The front end must tolerate one-cycle staleness.

## Structure
- Package occ_pkg holds:
  - NUM_STRIPS, STRIP_CAP, OCC_W;
  - the 4-bit strip-id and OCC_W occupied-width typedefs;
  - the FSM state enum {CLEAR, IDLE}.
- Sub-module occ_width_table: NUM_STRIPS x OCC_W register array with one write port and three registered read ports.
  - Contains the sentinel logic and the OCC_BYPASS_EN forwarding.
  - The top holds the FSM, sweep counter, S1 stage and capacity check.

## Test plan
- Reset 1 cycle, then idle: busy=1 for 13 cycles, then wr_ready=1. Reading ids 1,5,13 gives 0,0,0; reading id 0 gives 128.
- Write id 3 width 20, then id 3 width 30 back-to-back: done_occ_width 20 then 50, both done_ok=1. A later read of id 3 gives 50.
- Write id 7 width 31 five times: values 31,62,93,124. The 5th is rejected with done_ok=0 and done_occ_width=124, table unchanged.
- Write id 0 and id 14: done_ok=0, done_occ_width=128, no table change.
- Write id 2 width 10 at edge N, with rd_str_id_1=2 sampled at the commit edge: reads 10 with OCC_BYPASS_EN defined, 0 without.
- clr_req held high with wr_valid high for 1 cycle while S1 holds a pending write:
  - wr_ready=0 that cycle;
  - the pending write's done strobe appears;
  - busy=1 for 13 cycles;
  - afterwards, all real strips read 0.
